// File: rtl/hrmf_reorder_if.sv
// Stream bundle between the HRMF core outputs and the reorder buffer.
// The master side feeds digit-reversed beats and consumes natural-order beats.
interface hrmf_reorder_if #(
    parameter int W = 64
);
    logic         IN_VALID;
    logic         IN_SOF;
    logic         IN_READY;
    logic [W-1:0] D0;
    logic [W-1:0] D1;
    logic [W-1:0] D2;
    logic [W-1:0] D3;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic         OUT_SOF;
    logic         OUT_EOF;
    logic [W-1:0] Q0;
    logic [W-1:0] Q1;
    logic [W-1:0] Q2;
    logic [W-1:0] Q3;
    logic         ERR;

    modport master (
        output IN_VALID, IN_SOF, D0, D1, D2, D3, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_SOF, OUT_EOF, Q0, Q1, Q2, Q3, ERR
    );

    modport slave (
        input  IN_VALID, IN_SOF, D0, D1, D2, D3, OUT_READY,
        output IN_READY, OUT_VALID, OUT_SOF, OUT_EOF, Q0, Q1, Q2, Q3, ERR
    );
endinterface

// File: rtl/hrmf_reorder.sv
// Ping-pong reorder buffer: stores a 16-point frame delivered as a 4x4 transposed
// beat sequence and replays it in natural order.
module hrmf_reorder #(
    parameter int W = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    hrmf_reorder_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_t;

    bank_state_t  bank_q [2];
    bank_state_t  bank_d [2];
    logic         wb;
    logic         rb;
    logic [1:0]   wc;
    logic [1:0]   rc;
    logic         err;
    logic [W-1:0] mem [2][16];

    logic         in_ready;
    logic         out_valid;
    logic         wr_en;
    logic         rd_en;
    logic [1:0]   wc_eff;
    logic         wr_last;
    logic         rd_last;

    assign in_ready  = (bank_q[wb] == EMPTY) || (bank_q[wb] == FILL);
    assign out_valid = (bank_q[rb] == FULL) || (bank_q[rb] == DRAIN);
    assign wr_en     = bus.IN_VALID && in_ready;
    assign rd_en     = out_valid && bus.OUT_READY;
    // A start-of-frame beat always lands as beat 0, overwriting any partial frame.
    assign wc_eff    = bus.IN_SOF ? 2'd0 : wc;
    assign wr_last   = (wc_eff == 2'd3);
    assign rd_last   = (rc == 2'd3);

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_SOF   = out_valid && (rc == 2'd0);
    assign bus.OUT_EOF   = out_valid && (rc == 2'd3);
    assign bus.Q0        = mem[rb][{rc, 2'd0}];
    assign bus.Q1        = mem[rb][{rc, 2'd1}];
    assign bus.Q2        = mem[rb][{rc, 2'd2}];
    assign bus.Q3        = mem[rb][{rc, 2'd3}];
    assign bus.ERR       = err;

    // Write and read can never target the same bank: their state conditions are disjoint.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (wr_en) bank_d[wb] = wr_last ? FULL : FILL;
        if (rd_en) bank_d[rb] = rd_last ? EMPTY : DRAIN;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wb        <= 1'b0;
            rb        <= 1'b0;
            wc        <= '0;
            rc        <= '0;
            err       <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            if (wr_en) begin
                wc <= wr_last ? 2'd0 : wc_eff + 2'd1;
                if (wr_last) wb <= ~wb;
                if (bus.IN_SOF && (wc != 2'd0)) err <= 1'b1;
            end
            if (rd_en) begin
                rc <= rc + 2'd1;
                if (rd_last) rb <= ~rb;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < 16; i++)
                    mem[b][i] <= '0;
        end else if (wr_en) begin
            mem[wb][{2'd0, wc_eff}] <= bus.D0;
            mem[wb][{2'd1, wc_eff}] <= bus.D1;
            mem[wb][{2'd2, wc_eff}] <= bus.D2;
            mem[wb][{2'd3, wc_eff}] <= bus.D3;
        end
    end
endmodule

// File: tb/tb_hrmf_reorder.sv
// Bench for hrmf_reorder: transpose reference model, scenario tasks, random backpressure.
module tb_hrmf_reorder;
    localparam int W = 64;

    typedef struct packed {
        logic [3:0][W-1:0] lanes;
        logic              sof;
        logic              eof;
    } beat_t;

    typedef struct packed {
        logic [3:0][W-1:0] lanes;
        logic              sof;
    } in_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    beat_t             exp_q [$];
    in_t               in_q [$];
    logic [3:0][W-1:0] part [4];
    int                part_n;
    logic              err_exp;

    hrmf_reorder_if #(.W(W)) bus ();

    hrmf_reorder #(.W(W)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: collect beats into X[4l+c], emit beats carrying X[4c+l].
    function automatic void model_in(input logic [3:0][W-1:0] lanes, input logic sof);
        logic [W-1:0] x [16];
        beat_t        b;
        if (sof && part_n != 0) begin
            part_n  = 0;
            err_exp = 1'b1;
        end
        part[part_n] = lanes;
        part_n++;
        if (part_n == 4) begin
            for (int k = 0; k < 16; k++) x[k] = part[k % 4][k / 4];
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < 4; l++) b.lanes[l] = x[4 * c + l];
                b.sof = (c == 0);
                b.eof = (c == 3);
                exp_q.push_back(b);
            end
            part_n = 0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        in_q.delete();
        part_n  = 0;
        err_exp = 1'b0;
    endfunction

    function automatic void push_beat(input logic [3:0][W-1:0] lanes, input logic sof);
        in_t t;
        t.lanes = lanes;
        t.sof   = sof;
        in_q.push_back(t);
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock: drive the next pending input, sample at the falling edge, then
    // advance the model with whatever handshakes happened at the rising edge.
    task automatic step(input bit allow_in, output bit inf, output bit of, output bit ov,
                        output bit ir, output beat_t obs, output beat_t expb, output bit he);
        if (in_q.size() > 0 && allow_in) begin
            bus.IN_VALID = 1'b1;
            bus.IN_SOF   = in_q[0].sof;
            bus.D0       = in_q[0].lanes[0];
            bus.D1       = in_q[0].lanes[1];
            bus.D2       = in_q[0].lanes[2];
            bus.D3       = in_q[0].lanes[3];
        end else begin
            bus.IN_VALID = 1'b0;
            bus.IN_SOF   = 1'b0;
        end
        @(negedge clk);
        inf       = bus.IN_VALID && bus.IN_READY;
        of        = bus.OUT_VALID && bus.OUT_READY;
        ov        = bus.OUT_VALID;
        ir        = bus.IN_READY;
        obs.lanes = {bus.Q3, bus.Q2, bus.Q1, bus.Q0};
        obs.sof   = bus.OUT_SOF;
        obs.eof   = bus.OUT_EOF;
        he        = (exp_q.size() > 0);
        expb      = he ? exp_q[0] : '0;
        @(posedge clk);
        #1;
        if (of && he) void'(exp_q.pop_front());
        if (inf) begin
            in_t t;
            t = in_q.pop_front();
            model_in(t.lanes, t.sof);
        end
    endtask

    task automatic do_reset();
        bus.IN_VALID  = 1'b0;
        bus.IN_SOF    = 1'b0;
        bus.D0        = '0;
        bus.D1        = '0;
        bus.D2        = '0;
        bus.D3        = '0;
        bus.OUT_READY = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY); end
        n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.OUT_VALID); end
        n_checks++; if (bus.OUT_SOF !== 1'b0) begin n_fail++; $display("FAIL reset_out_sof: got %b want 0", bus.OUT_SOF); end
        n_checks++; if (bus.OUT_EOF !== 1'b0) begin n_fail++; $display("FAIL reset_out_eof: got %b want 0", bus.OUT_EOF); end
        n_checks++; if ({bus.Q3, bus.Q2, bus.Q1, bus.Q0} !== '0) begin n_fail++; $display("FAIL reset_q: got %h want 0", {bus.Q3, bus.Q2, bus.Q1, bus.Q0}); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        bit inf, of, ov, ir, he;
        beat_t obs, expb, e;
        logic [3:0][W-1:0] lanes;
        int acc = 0, outs = 0, acc3_cyc = -1, first_valid = -1;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) lanes[l] = {32'(4 * l + c), 32'd0};
            push_beat(lanes, c == 0);
        end
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 20 && outs < 4; cyc++) begin
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            if (ov && first_valid < 0) first_valid = cyc;
            if (inf) begin
                acc++;
                if (acc == 4) acc3_cyc = cyc;
            end
            if (of) begin
                for (int l = 0; l < 4; l++) e.lanes[l] = {32'(4 * outs + l), 32'd0};
                e.sof = (outs == 0);
                e.eof = (outs == 3);
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL single_beat%0d: got %h want %h", outs, obs, e); end
                outs++;
            end
        end
        n_checks++; if (first_valid !== acc3_cyc + 1) begin n_fail++; $display("FAIL single_latency: valid cycle %0d want %0d", first_valid, acc3_cyc + 1); end
        n_checks++; if (outs !== 4) begin n_fail++; $display("FAIL single_count: got %0d beats want 4", outs); end
    endtask

    task automatic test_back_to_back();
        bit inf, of, ov, ir, he;
        beat_t obs, expb;
        logic [3:0][W-1:0] lanes;
        int outs = 0, first_out = -1, last_out = -1;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < 4; l++) lanes[l] = {32'(16 * f + 4 * l + c), 32'(f)};
                push_beat(lanes, c == 0);
            end
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 80 && outs < 32; cyc++) begin
            bit pending;
            pending = (in_q.size() > 0);
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            if (pending) begin
                n_checks++;
                if (ir !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: got %b want 1 at cycle %0d", ir, cyc); end
            end
            if (of) begin
                n_checks++;
                if (!he || obs !== expb) begin n_fail++; $display("FAIL stream_beat%0d: got %h want %h", outs, obs, expb); end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                outs++;
            end
        end
        n_checks++; if (outs !== 32) begin n_fail++; $display("FAIL stream_count: got %0d want 32", outs); end
        n_checks++; if (last_out - first_out !== 31) begin n_fail++; $display("FAIL stream_contiguous: span %0d want 31", last_out - first_out); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %b want 0", bus.ERR); end
    endtask

    task automatic test_backpressure();
        bit inf, of, ov, ir, he, exp_ir, have_ref;
        beat_t obs, expb, ref_beat;
        logic [3:0][W-1:0] lanes;
        int acc = 0, outs = 0;
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < 4; l++) lanes[l] = rnd64();
                push_beat(lanes, c == 0);
            end
        bus.OUT_READY = 1'b0;
        have_ref = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            exp_ir = (exp_q.size() <= 4);
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            if (inf) acc++;
            n_checks++;
            if (ir !== exp_ir) begin n_fail++; $display("FAIL bp_in_ready: got %b want %b at cycle %0d", ir, exp_ir, cyc); end
            if (ov) begin
                if (!have_ref) begin
                    ref_beat = obs;
                    have_ref = 1'b1;
                    n_checks++;
                    if (!he || obs !== expb) begin n_fail++; $display("FAIL bp_stall_head: got %h want %h", obs, expb); end
                end else begin
                    n_checks++;
                    if (obs !== ref_beat) begin n_fail++; $display("FAIL bp_stall_stable: got %h want %h", obs, ref_beat); end
                end
            end
        end
        n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", acc); end
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 60 && outs < 12; cyc++) begin
            exp_ir = (exp_q.size() <= 4);
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            n_checks++;
            if (ir !== exp_ir) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want %b at cycle %0d", ir, exp_ir, cyc); end
            if (of) begin
                n_checks++;
                if (!he || obs !== expb) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", outs, obs, expb); end
                outs++;
            end
        end
        n_checks++; if (outs !== 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", outs); end
    endtask

    task automatic test_resync();
        bit inf, of, ov, ir, he;
        beat_t obs, expb;
        logic [3:0][W-1:0] lanes;
        int outs = 0;
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL resync_err_before: got %b want 0", bus.ERR); end
        for (int b = 0; b < 6; b++) begin
            for (int l = 0; l < 4; l++) lanes[l] = rnd64();
            push_beat(lanes, b == 0 || b == 2);
        end
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 40 && (in_q.size() > 0 || exp_q.size() > 0); cyc++) begin
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            if (of) begin
                n_checks++;
                if (!he || obs !== expb) begin n_fail++; $display("FAIL resync_beat%0d: got %h want %h", outs, obs, expb); end
                outs++;
            end
        end
        n_checks++; if (outs !== 4) begin n_fail++; $display("FAIL resync_count: got %0d want 4", outs); end
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL resync_err: got %b want 1", bus.ERR); end
    endtask

    task automatic test_random_ready();
        bit inf, of, ov, ir, he, exp_ir;
        beat_t obs, expb;
        logic [3:0][W-1:0] lanes;
        int outs = 0;
        for (int f = 0; f < 100; f++)
            for (int c = 0; c < 4; c++) begin
                for (int l = 0; l < 4; l++) lanes[l] = rnd64();
                push_beat(lanes, c == 0);
            end
        for (int cyc = 0; cyc < 5000 && (in_q.size() > 0 || exp_q.size() > 0); cyc++) begin
            bus.OUT_READY = 1'($urandom_range(0, 1));
            exp_ir = (exp_q.size() <= 4);
            step($urandom_range(0, 3) != 0, inf, of, ov, ir, obs, expb, he);
            n_checks++;
            if (ir !== exp_ir) begin n_fail++; $display("FAIL rand_in_ready: got %b want %b at cycle %0d", ir, exp_ir, cyc); end
            if (of) begin
                n_checks++;
                if (!he || obs !== expb) begin n_fail++; $display("FAIL rand_beat%0d: got %h want %h", outs, obs, expb); end
                outs++;
            end
        end
        n_checks++; if (outs !== 400) begin n_fail++; $display("FAIL rand_count: got %0d want 400", outs); end
        n_checks++; if (bus.ERR !== err_exp) begin n_fail++; $display("FAIL rand_err: got %b want %b", bus.ERR, err_exp); end
    endtask

    task automatic test_reset_midframe();
        bit inf, of, ov, ir, he;
        beat_t obs, expb;
        logic [3:0][W-1:0] lanes;
        int outs = 0;
        bus.OUT_READY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < 4; l++) lanes[l] = rnd64();
            push_beat(lanes, b == 0);
        end
        for (int cyc = 0; cyc < 2; cyc++) step(1'b1, inf, of, ov, ir, obs, expb, he);
        bus.IN_VALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.OUT_VALID); end
        n_checks++; if ({bus.OUT_SOF, bus.OUT_EOF} !== 2'b00) begin n_fail++; $display("FAIL midrst_sof_eof: got %b want 00", {bus.OUT_SOF, bus.OUT_EOF}); end
        n_checks++; if ({bus.Q3, bus.Q2, bus.Q1, bus.Q0} !== '0) begin n_fail++; $display("FAIL midrst_q: got %h want 0", {bus.Q3, bus.Q2, bus.Q1, bus.Q0}); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", bus.ERR); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) lanes[l] = rnd64();
            push_beat(lanes, c == 0);
        end
        for (int cyc = 0; cyc < 30 && (in_q.size() > 0 || exp_q.size() > 0); cyc++) begin
            step(1'b1, inf, of, ov, ir, obs, expb, he);
            if (of) begin
                n_checks++;
                if (!he || obs !== expb) begin n_fail++; $display("FAIL midrst_beat%0d: got %h want %h", outs, obs, expb); end
                outs++;
            end
        end
        n_checks++; if (outs !== 4) begin n_fail++; $display("FAIL midrst_count: got %0d want 4", outs); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_random_ready();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
